// File: rtl/neuron_seq_mac.sv
// Sequential single-neuron MAC: weighted sum of a sample vector with sign-magnitude
// weights, split into positive/negative saturating accumulators, followed by a sigmoid LUT.
module neuron_seq_mac #(
    parameter int unsigned BROJ_ULAZA = 60,
    parameter int unsigned SIRINA     = 16,
    parameter int unsigned ACC_W      = 22
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           tez_we,
    input  logic [$clog2(BROJ_ULAZA)-1:0]  tez_addr,
    input  logic [SIRINA-1:0]              tez_data,
    input  logic [BROJ_ULAZA*SIRINA-1:0]   uzorak,
    input  logic                           uzorak_valid,
    output logic                           uzorak_ready,
    output logic [15:0]                    izlaz,
    output logic                           izlaz_valid,
    output logic [ACC_W-1:0]               suma_o,
    output logic                           predznak_o
);

    localparam int unsigned AW = $clog2(BROJ_ULAZA);
    localparam int unsigned VW = BROJ_ULAZA * SIRINA;
    localparam int unsigned PW = 2 * SIRINA - 1;
    localparam int unsigned LW = 22;

    typedef enum logic [1:0] {IDLE, MAC, DIFF, OUT} state_t;

    state_t             state_q, state_n;
    logic [SIRINA-1:0]  tez_q [BROJ_ULAZA];
    logic [VW-1:0]      uzorak_q;
    logic [AW-1:0]      idx_q;
    logic [ACC_W-1:0]   acc_p_q, acc_n_q;

    logic               accept_c;
    logic               wr_en_c;
    logic               last_c;
    logic [SIRINA-1:0]  w_cur_c;
    logic [SIRINA-1:0]  s_cur_c;
    logic [PW-1:0]      prod_full_c;
    logic [SIRINA-1:0]  prod_c;
    logic [ACC_W:0]     sum_p_c, sum_n_c;
    logic [ACC_W-1:0]   sat_p_c, sat_n_c;
    logic [15:0]        lut_c;

    // Piecewise-linear sigmoid; magnitude is Q6.16 (65536 = 1.0), output Q0.16.
    function automatic logic [15:0] sigmoid_lut(input logic [LW-1:0] mag, input logic neg);
        logic [16:0] y;
        if (mag < LW'(65536))
            y = 17'(mag >> 2) + 17'd32768;
        else if (mag < LW'(155648))
            y = 17'(mag >> 3) + 17'd40960;
        else if (mag < LW'(327680))
            y = 17'(mag >> 5) + 17'd55296;
        else
            y = 17'd65535;
        if (y > 17'd65535)
            y = 17'd65535;
        return neg ? 16'(17'd65536 - y) : 16'(y);
    endfunction

    // Next-state logic
    always_comb begin
        state_n  = state_q;
        accept_c = uzorak_valid && uzorak_ready;
        last_c   = (idx_q == AW'(BROJ_ULAZA - 1));
        unique case (state_q)
            IDLE: if (accept_c) state_n = MAC;
            MAC:  if (last_c)   state_n = DIFF;
            DIFF: state_n = OUT;
            OUT:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Datapath: current product, saturating sums, LUT lookup
    always_comb begin
        wr_en_c     = tez_we && (32'(tez_addr) < BROJ_ULAZA);
        w_cur_c     = tez_q[idx_q];
        s_cur_c     = uzorak_q[32'(idx_q) * SIRINA +: SIRINA];
        prod_full_c = PW'(w_cur_c[SIRINA-2:0]) * PW'(s_cur_c);
        prod_c      = SIRINA'(prod_full_c >> (SIRINA - 1));
        sum_p_c     = (ACC_W+1)'(acc_p_q) + (ACC_W+1)'(prod_c);
        sum_n_c     = (ACC_W+1)'(acc_n_q) + (ACC_W+1)'(prod_c);
        sat_p_c     = sum_p_c[ACC_W] ? '1 : sum_p_c[ACC_W-1:0];
        sat_n_c     = sum_n_c[ACC_W] ? '1 : sum_n_c[ACC_W-1:0];
        lut_c       = sigmoid_lut(LW'(suma_o), predznak_o);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            uzorak_q     <= '0;
            idx_q        <= '0;
            acc_p_q      <= '0;
            acc_n_q      <= '0;
            izlaz        <= '0;
            izlaz_valid  <= 1'b0;
            suma_o       <= '0;
            predznak_o   <= 1'b0;
            uzorak_ready <= 1'b1;
            for (int i = 0; i < int'(BROJ_ULAZA); i++)
                tez_q[i] <= '0;
        end else begin
            state_q     <= state_n;
            izlaz_valid <= (state_q == OUT);
            // The result-strobe cycle is a cool-down: no accept while izlaz_valid is high.
            uzorak_ready <= (state_n == IDLE) && (state_q != OUT);
            case (state_q)
                IDLE: begin
                    if (accept_c) begin
                        uzorak_q <= uzorak;
                        acc_p_q  <= '0;
                        acc_n_q  <= '0;
                        idx_q    <= '0;
                    end else if (wr_en_c) begin
                        tez_q[tez_addr] <= tez_data;
                    end
                end
                MAC: begin
                    if (w_cur_c[SIRINA-1])
                        acc_n_q <= sat_n_c;
                    else
                        acc_p_q <= sat_p_c;
                    idx_q <= last_c ? '0 : idx_q + AW'(1);
                end
                DIFF: begin
                    if (acc_p_q > acc_n_q) begin
                        suma_o     <= acc_p_q - acc_n_q;
                        predznak_o <= 1'b0;
                    end else begin
                        suma_o     <= acc_n_q - acc_p_q;
                        predznak_o <= 1'b1;
                    end
                end
                OUT: izlaz <= lut_c;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_seq_mac.sv
// Bench for neuron_seq_mac: two instances (ACC_W=22 and ACC_W=16) share stimulus and are
// checked against a plain-arithmetic neuron model, a hand-computed vector table and corner sequences.
module tb_neuron_seq_mac;

    localparam int unsigned N  = 4;
    localparam int unsigned S  = 16;
    localparam int unsigned VW = N * S;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          tez_we;
    logic [1:0]    tez_addr;
    logic [S-1:0]  tez_data;
    logic [VW-1:0] uzorak;
    logic          uzorak_valid;

    logic          rdy_a, vld_a, pred_a;
    logic [15:0]   izl_a;
    logic [21:0]   suma_a;
    logic          rdy_b, vld_b, pred_b;
    logic [15:0]   izl_b;
    logic [15:0]   suma_b;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] w_m [N];

    typedef struct {
        logic [VW-1:0] w;
        logic [VW-1:0] s;
        longint        suma22;
        bit            pred22;
        longint        suma16;
        bit            pred16;
    } vec_t;

    vec_t tbl [5];

    neuron_seq_mac #(.BROJ_ULAZA(N), .SIRINA(S), .ACC_W(22)) dut (
        .clk(clk), .rst_n(rst_n), .tez_we(tez_we), .tez_addr(tez_addr), .tez_data(tez_data),
        .uzorak(uzorak), .uzorak_valid(uzorak_valid), .uzorak_ready(rdy_a),
        .izlaz(izl_a), .izlaz_valid(vld_a), .suma_o(suma_a), .predznak_o(pred_a)
    );

    neuron_seq_mac #(.BROJ_ULAZA(N), .SIRINA(S), .ACC_W(16)) dut_sat (
        .clk(clk), .rst_n(rst_n), .tez_we(tez_we), .tez_addr(tez_addr), .tez_data(tez_data),
        .uzorak(uzorak), .uzorak_valid(uzorak_valid), .uzorak_ready(rdy_b),
        .izlaz(izl_b), .izlaz_valid(vld_b), .suma_o(suma_b), .predznak_o(pred_b)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // izlaz must track the logistic function of +/- suma/65536 within a small error
    task automatic check_sig(input string name, input longint izl, input longint suma, input bit pred);
        real x, want, got, err;
        n_checks++;
        x    = real'(suma) / 65536.0;
        if (pred) x = -x;
        want = 1.0 / (1.0 + $exp(-x));
        got  = real'(izl) / 65536.0;
        err  = (got > want) ? got - want : want - got;
        if (err > 0.03) begin
            n_fail++;
            $display("FAIL %s: izlaz %0d, expected about %0d", name, izl, longint'(want * 65536.0));
        end
    endtask

    // Reference neuron: products split by weight sign into clamped sums, then |P-N| and sign
    task automatic model(input logic [VW-1:0] sv, input int acc_w, output longint suma, output bit pred);
        longint cap, p, n, mag, sk, wk;
        cap = (longint'(1) << acc_w) - 1;
        p = 0;
        n = 0;
        for (int k = 0; k < int'(N); k++) begin
            wk  = longint'(w_m[k][14:0]);
            sk  = longint'(sv[k*S +: S]);
            mag = ((wk * sk) >> 15) & 64'hFFFF;
            if (w_m[k][15]) n = (n + mag > cap) ? cap : n + mag;
            else            p = (p + mag > cap) ? cap : p + mag;
        end
        if (p > n) begin suma = p - n; pred = 1'b0; end
        else       begin suma = n - p; pred = 1'b1; end
    endtask

    task automatic write_weight(input int addr, input logic [15:0] data);
        tez_we   = 1'b1;
        tez_addr = 2'(addr);
        tez_data = data;
        tick();
        tez_we   = 1'b0;
        w_m[addr] = data;
    endtask

    task automatic load_weights(input logic [VW-1:0] wv);
        for (int k = 0; k < int'(N); k++)
            write_weight(k, wv[k*S +: S]);
    endtask

    // One transaction: accept, watch latency/ready, check izlaz; returns the result ports
    task automatic run_sample(input logic [VW-1:0] sv, input bit busy_wr,
                              output longint sa, output bit pa, output longint sb, output bit pb);
        int guard, lat, low;
        guard = 0;
        while (!rdy_a && guard < 20) begin tick(); guard++; end
        check("ready_before_accept", longint'(rdy_a), 1);
        uzorak       = sv;
        uzorak_valid = 1'b1;
        tez_we       = busy_wr;
        tez_addr     = 2'd0;
        tez_data     = 16'h4000;
        tick();
        uzorak_valid = 1'b0;
        uzorak       = {$urandom(), $urandom()};
        low = rdy_a ? 0 : 1;
        lat = 0;
        while (lat < 20) begin
            tick();
            lat++;
            if (!rdy_a) low++;
            if (vld_a) break;
        end
        tez_we = 1'b0;
        check("valid_latency", longint'(lat), longint'(N + 2));
        check("ready_low_cycles", longint'(low), longint'(N + 3));
        check("valid_both", longint'(vld_b), 1);
        sa = longint'(suma_a); pa = pred_a;
        sb = longint'(suma_b); pb = pred_b;
        check_sig("izlaz_a", longint'(izl_a), sa, pa);
        check_sig("izlaz_b", longint'(izl_b), sb, pb);
        tick();
        check("valid_one_cycle", longint'(vld_a), 0);
        check("ready_after_result", longint'(rdy_a), 1);
        check("suma_hold", longint'(suma_a), sa);
    endtask

    task automatic run_and_model(input logic [VW-1:0] sv, input bit busy_wr, input string tag);
        longint sa, sb, ea, eb;
        bit pa, pb, qa, qb;
        model(sv, 22, ea, qa);
        model(sv, 16, eb, qb);
        run_sample(sv, busy_wr, sa, pa, sb, pb);
        check({tag, "_suma22"}, sa, ea);
        check({tag, "_pred22"}, longint'(pa), longint'(qa));
        check({tag, "_suma16"}, sb, eb);
        check({tag, "_pred16"}, longint'(pb), longint'(qb));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        longint sa, sb;
        bit pa, pb;
        int seen;
        logic [VW-1:0] wv, sv;

        tbl[0] = '{w: {4{16'h4000}}, s: {4{16'h8000}}, suma22: 65536, pred22: 0, suma16: 65535, pred16: 0};
        tbl[1] = '{w: {4{16'hC000}}, s: {4{16'h8000}}, suma22: 65536, pred22: 1, suma16: 65535, pred16: 1};
        tbl[2] = '{w: {16'h0000, 16'h0000, 16'hC000, 16'h4000}, s: {4{16'h8000}},
                   suma22: 0, pred22: 1, suma16: 0, pred16: 1};
        tbl[3] = '{w: {4{16'h7FFF}}, s: {4{16'hFFFF}}, suma22: 262132, pred22: 0, suma16: 65535, pred16: 0};
        tbl[4] = '{w: {16'hA000, 16'h8000, 16'h2000, 16'h4000}, s: {16'h0100, 16'hFFFF, 16'hFFFF, 16'h1000},
                   suma22: 18367, pred22: 0, suma16: 18367, pred16: 0};
        for (int k = 0; k < int'(N); k++) w_m[k] = 16'h0;

        // Reset with garbage on the inputs
        rst_n        = 1'b0;
        tez_we       = 1'b1;
        tez_addr     = 2'($urandom());
        tez_data     = 16'($urandom());
        uzorak       = {$urandom(), $urandom()};
        uzorak_valid = 1'b1;
        tick(); tick(); tick();
        check("rst_izlaz", longint'(izl_a), 0);
        check("rst_valid", longint'(vld_a), 0);
        check("rst_suma", longint'(suma_a), 0);
        check("rst_pred", longint'(pred_a), 0);
        tez_we = 1'b0;
        uzorak_valid = 1'b0;
        rst_n = 1'b1;
        check("rst_ready_release", longint'(rdy_a), 1);
        tick();
        check("rst_ready_idle", longint'(rdy_a), 1);

        // Weights come out of reset as zero
        run_and_model({$urandom(), $urandom()}, 1'b0, "post_reset");
        check("post_reset_suma", longint'(suma_a), 0);
        check("post_reset_pred", longint'(pred_a), 1);

        // Hand-computed vector table
        for (int i = 0; i < 5; i++) begin
            load_weights(tbl[i].w);
            run_sample(tbl[i].s, 1'b0, sa, pa, sb, pb);
            check($sformatf("tbl%0d_suma22", i), sa, tbl[i].suma22);
            check($sformatf("tbl%0d_pred22", i), longint'(pa), longint'(tbl[i].pred22));
            check($sformatf("tbl%0d_suma16", i), sb, tbl[i].suma16);
            check($sformatf("tbl%0d_pred16", i), longint'(pb), longint'(tbl[i].pred16));
        end
        check("tbl0_izlaz_positive", longint'(izl_a >= 16'h8000), 1);

        // Weight write during MAC is dropped, the same write in IDLE lands
        load_weights({16'h4000, 16'h4000, 16'h4000, 16'h0000});
        run_sample({4{16'h8000}}, 1'b1, sa, pa, sb, pb);
        check("busy_write_suma", sa, 49152);
        check("busy_write_pred", longint'(pa), 0);
        write_weight(0, 16'h4000);
        run_sample({4{16'h8000}}, 1'b0, sa, pa, sb, pb);
        check("idle_write_suma", sa, 65536);

        // Reset two cycles into MAC aborts the sample and clears weights
        while (!rdy_a) tick();
        uzorak       = {4{16'h8000}};
        uzorak_valid = 1'b1;
        tick();
        uzorak_valid = 1'b0;
        tick(); tick();
        rst_n = 1'b0;
        #1;
        check("abort_izlaz", longint'(izl_a), 0);
        check("abort_suma", longint'(suma_a), 0);
        check("abort_valid", longint'(vld_a), 0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < int'(N); k++) w_m[k] = 16'h0;
        check("abort_ready_release", longint'(rdy_a), 1);
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (vld_a) seen++;
        end
        check("abort_no_valid", longint'(seen), 0);
        run_and_model({$urandom(), $urandom()}, 1'b0, "after_abort");
        check("after_abort_suma", longint'(suma_a), 0);
        check("after_abort_pred", longint'(pred_a), 1);
        check("after_abort_izlaz", longint'(izl_a), 32768);

        // Random weights/samples against the model, with random busy writes
        for (int it = 0; it < 30; it++) begin
            wv = {$urandom(), $urandom()};
            for (int k = 0; k < int'(N); k++)
                if ($urandom_range(0, 5) == 0) wv[k*S +: S] = ($urandom_range(0, 1) == 1) ? 16'h8000 : 16'h0000;
            load_weights(wv);
            sv = {$urandom(), $urandom()};
            run_and_model(sv, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", it));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
